// File: rtl/rob_pkg.sv
// Shared types and default widths for the ROB commit path.
// The default widths also seed the parameters of rob_commit_ctrl.
package rob_pkg;

  localparam int unsigned RobSizeDef     = 8;
  localparam int unsigned RegAddrSizeDef = 5;
  localparam int unsigned DataWidthDef   = 32;

  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      exc;
    logic [RegAddrSizeDef-1:0] dest;
    logic [DataWidthDef-1:0]   data;
  } robEntry_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCommit = 2'd1,
    StFlush  = 2'd2
  } commitState_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: alloc and CDB write ports, global clear, one async read port.
// Write priority per entry is clear > alloc > (retire, CDB).
module rob_entry_array
  import rob_pkg::*;
#(
  parameter int unsigned Depth = RobSizeDef,
  parameter int unsigned AddrW = $clog2(Depth),
  parameter int unsigned DestW = RegAddrSizeDef,
  parameter int unsigned DataW = DataWidthDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic [AddrW-1:0] alloc_idx_i,
  input  logic [DestW-1:0] alloc_dest_i,
  input  logic             cdb_valid_i,
  input  logic [AddrW-1:0] cdb_tag_i,
  input  logic [DataW-1:0] cdb_data_i,
  input  logic             cdb_exc_i,
  input  logic             retire_i,
  input  logic [AddrW-1:0] retire_idx_i,
  input  logic             clear_i,
  input  logic [AddrW-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic             rd_done_o,
  output logic             rd_exc_o,
  output logic [DestW-1:0] rd_dest_o,
  output logic [DataW-1:0] rd_data_o
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] done_q;
  logic [Depth-1:0] exc_q;
  logic [DestW-1:0] dest_q [Depth];
  logic [DataW-1:0] data_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (alloc_i && alloc_idx_i == AddrW'(i)) begin
          valid_q[i] <= 1'b1;
          done_q[i]  <= 1'b0;
          exc_q[i]   <= 1'b0;
        end else begin
          if (retire_i && retire_idx_i == AddrW'(i)) begin
            valid_q[i] <= 1'b0;
          end
          if (cdb_valid_i && cdb_tag_i == AddrW'(i) && valid_q[i]) begin
            done_q[i] <= 1'b1;
            exc_q[i]  <= cdb_exc_i;
          end
        end
      end
    end
  end

  // Payload needs no reset: it is only observed behind valid/done.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (alloc_i && alloc_idx_i == AddrW'(i)) begin
        dest_q[i] <= alloc_dest_i;
      end else if (cdb_valid_i && cdb_tag_i == AddrW'(i) && valid_q[i]) begin
        data_q[i] <= cdb_data_i;
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_done_o  = done_q[rd_idx_i];
  assign rd_exc_o   = exc_q[rd_idx_i];
  assign rd_dest_o  = dest_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB retire engine: offers the head entry to the register file or flushes on exception.
// Define ROB_COMMIT_BYPASS_EN to forward a CDB result for the head straight into the commit offer.
module rob_commit_ctrl
  import rob_pkg::*;
#(
  parameter int unsigned ROBsize     = RobSizeDef,
  parameter int unsigned addrSize    = $clog2(ROBsize),
  parameter int unsigned regAddrSize = RegAddrSizeDef,
  parameter int unsigned dataWidth   = DataWidthDef
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   alloc_i,
  input  logic [addrSize-1:0]    allocTail_i,
  input  logic [regAddrSize-1:0] allocDest_i,
  input  logic                   cdbValid_i,
  input  logic [addrSize-1:0]    cdbTag_i,
  input  logic [dataWidth-1:0]   cdbData_i,
  input  logic                   cdbExc_i,
  input  logic [addrSize-1:0]    head_i,
  input  logic                   commitReady_i,
  output logic                   commitValid_o,
  output logic [regAddrSize-1:0] commitDest_o,
  output logic [dataWidth-1:0]   commitData_o,
  output logic [addrSize-1:0]    commitTag_o,
  output logic                   updateHead_o,
  output logic                   flush_o,
  output logic [1:0]             state_o
);

  commitState_t           state_q;
  logic                   commit_valid_q;
  logic                   flush_q;
  logic [regAddrSize-1:0] dest_q;
  logic [dataWidth-1:0]   data_q;
  logic [addrSize-1:0]    tag_q;

  logic                   head_valid;
  logic                   head_done;
  logic                   head_exc;
  logic [regAddrSize-1:0] head_dest;
  logic [dataWidth-1:0]   head_data;
  logic                   handshake;
  logic                   head_ready;
  logic                   bypass_hit;

  rob_entry_array #(
    .Depth(ROBsize),
    .AddrW(addrSize),
    .DestW(regAddrSize),
    .DataW(dataWidth)
  ) u_entries (
    .clk_i       (clk_i),
    .rst_ni      (reset_n_i),
    .alloc_i     (alloc_i),
    .alloc_idx_i (allocTail_i),
    .alloc_dest_i(allocDest_i),
    .cdb_valid_i (cdbValid_i),
    .cdb_tag_i   (cdbTag_i),
    .cdb_data_i  (cdbData_i),
    .cdb_exc_i   (cdbExc_i),
    .retire_i    (handshake),
    .retire_idx_i(tag_q),
    .clear_i     (flush_q),
    .rd_idx_i    (head_i),
    .rd_valid_o  (head_valid),
    .rd_done_o   (head_done),
    .rd_exc_o    (head_exc),
    .rd_dest_o   (head_dest),
    .rd_data_o   (head_data)
  );

  assign handshake  = commit_valid_q & commitReady_i;
  assign head_ready = head_valid & head_done;

`ifdef ROB_COMMIT_BYPASS_EN
  // A same-edge alloc to the head replaces the entry, so the CDB result must not be forwarded.
  assign bypass_hit = cdbValid_i && (cdbTag_i == head_i) && head_valid && !cdbExc_i &&
                      !(alloc_i && (allocTail_i == head_i));
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= StIdle;
      commit_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      dest_q         <= '0;
      data_q         <= '0;
      tag_q          <= '0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (head_ready && !head_exc) begin
            state_q        <= StCommit;
            commit_valid_q <= 1'b1;
            dest_q         <= head_dest;
            data_q         <= head_data;
            tag_q          <= head_i;
          end else if (head_ready) begin
            state_q <= StFlush;
            flush_q <= 1'b1;
          end else if (bypass_hit) begin
            state_q        <= StCommit;
            commit_valid_q <= 1'b1;
            dest_q         <= head_dest;
            data_q         <= cdbData_i;
            tag_q          <= head_i;
          end
        end
        StCommit: begin
          if (commitReady_i) begin
            state_q        <= StIdle;
            commit_valid_q <= 1'b0;
          end
        end
        StFlush: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign commitValid_o = commit_valid_q;
  assign commitDest_o  = dest_q;
  assign commitData_o  = data_q;
  assign commitTag_o   = tag_q;
  assign updateHead_o  = handshake;
  assign flush_o       = flush_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios, then random traffic vs a ROB model.
// Also covers the ROB_COMMIT_BYPASS_EN build when that macro is defined.
module tb_rob_commit_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int RW = 5;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic          alloc_i;
  logic [AW-1:0] allocTail_i;
  logic [RW-1:0] allocDest_i;
  logic          cdbValid_i;
  logic [AW-1:0] cdbTag_i;
  logic [DW-1:0] cdbData_i;
  logic          cdbExc_i;
  logic [AW-1:0] head_i;
  logic          commitReady_i;
  logic          commitValid_o;
  logic [RW-1:0] commitDest_o;
  logic [DW-1:0] commitData_o;
  logic [AW-1:0] commitTag_o;
  logic          updateHead_o;
  logic          flush_o;
  logic [1:0]    state_o;

  rob_commit_ctrl dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .alloc_i      (alloc_i),
    .allocTail_i  (allocTail_i),
    .allocDest_i  (allocDest_i),
    .cdbValid_i   (cdbValid_i),
    .cdbTag_i     (cdbTag_i),
    .cdbData_i    (cdbData_i),
    .cdbExc_i     (cdbExc_i),
    .head_i       (head_i),
    .commitReady_i(commitReady_i),
    .commitValid_o(commitValid_o),
    .commitDest_o (commitDest_o),
    .commitData_o (commitData_o),
    .commitTag_o  (commitTag_o),
    .updateHead_o (updateHead_o),
    .flush_o      (flush_o),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ROB contents plus the head/tail pointer manager that surrounds the DUT.
  logic          m_valid [N];
  logic          m_done  [N];
  logic          m_exc   [N];
  logic [RW-1:0] m_dest  [N];
  logic [DW-1:0] m_data  [N];
  logic [AW-1:0] m_head;
  logic [AW-1:0] m_tail;
  int            m_count;

  assign head_i      = m_head;
  assign allocTail_i = m_tail;

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] <= 1'b0;
        m_done[i]  <= 1'b0;
        m_exc[i]   <= 1'b0;
      end
      m_head  <= '0;
      m_tail  <= '0;
      m_count <= 0;
    end else if (flush_o) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] <= 1'b0;
        m_done[i]  <= 1'b0;
        m_exc[i]   <= 1'b0;
      end
      m_head  <= '0;
      m_tail  <= '0;
      m_count <= 0;
    end else begin
      if (cdbValid_i && m_valid[cdbTag_i]) begin
        m_done[cdbTag_i] <= 1'b1;
        m_exc[cdbTag_i]  <= cdbExc_i;
        m_data[cdbTag_i] <= cdbData_i;
      end
      if (updateHead_o) begin
        m_valid[m_head] <= 1'b0;
        m_head          <= m_head + 1'b1;
      end
      if (alloc_i) begin
        m_valid[m_tail] <= 1'b1;
        m_done[m_tail]  <= 1'b0;
        m_exc[m_tail]   <= 1'b0;
        m_dest[m_tail]  <= allocDest_i;
        m_tail          <= m_tail + 1'b1;
      end
      m_count <= m_count + (alloc_i ? 1 : 0) - (updateHead_o ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_cv"}, commitValid_o, 1'b0);
    check_eq({tag, "_upd"}, updateHead_o, 1'b0);
    check_eq({tag, "_flush"}, flush_o, 1'b0);
    check_eq({tag, "_state"}, state_o, 2'd0);
    check_eq({tag, "_dest"}, commitDest_o, '0);
    check_eq({tag, "_data"}, commitData_o, '0);
    check_eq({tag, "_tag"}, commitTag_o, '0);
  endtask

  logic [AW-1:0] cand[$];
  logic [AW-1:0] idx;
  logic [AW-1:0] rtag;
  logic [AW-1:0] p_tag  [3];
  logic [RW-1:0] p_dest [3];
  logic [DW-1:0] p_data [3];
  int            p_cyc  [3];
  int            n_pulse;
  int            n_flush;
  int            wait_cnt;
  logic          prev_flush;

  initial begin
    reset_n_i     = 1'b0;
    alloc_i       = 1'b0;
    allocDest_i   = '0;
    cdbValid_i    = 1'b0;
    cdbTag_i      = '0;
    cdbData_i     = '0;
    cdbExc_i      = 1'b0;
    commitReady_i = 1'b0;
    #12;
    check_quiet("rst");
    reset_n_i = 1'b1;
    step();

    // Single commit with latency, then a 4-cycle hold with ready low.
    alloc_i = 1'b1; allocDest_i = 5'd3;
    step();
    alloc_i = 1'b0;
    cdbValid_i = 1'b1; cdbTag_i = 3'd0; cdbData_i = 32'hDEAD;
    step();
    cdbValid_i = 1'b0;
`ifdef ROB_COMMIT_BYPASS_EN
    check_eq("lat_edge_n", commitValid_o, 1'b1);
`else
    check_eq("lat_edge_n", commitValid_o, 1'b0);
    step();
    check_eq("lat_edge_n1", commitValid_o, 1'b1);
`endif
    check_eq("t1_dest", commitDest_o, 5'd3);
    check_eq("t1_data", commitData_o, 32'hDEAD);
    check_eq("t1_tag", commitTag_o, 3'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq("hold_cv", commitValid_o, 1'b1);
      check_eq("hold_upd", updateHead_o, 1'b0);
      check_eq("hold_data", commitData_o, 32'hDEAD);
      check_eq("hold_dest", commitDest_o, 5'd3);
      step();
    end
    commitReady_i = 1'b1;
    #1;
    check_eq("hs_upd", updateHead_o, 1'b1);
    step();
    check_eq("post_hs_upd", updateHead_o, 1'b0);
    check_eq("post_hs_cv", commitValid_o, 1'b0);

    // Reset while a commit offer is pending.
    commitReady_i = 1'b0;
    alloc_i = 1'b1; allocDest_i = 5'd9;
    step();
    alloc_i = 1'b0;
    cdbValid_i = 1'b1; cdbTag_i = 3'd1; cdbData_i = 32'h1234;
    step();
    cdbValid_i = 1'b0;
    for (int k = 0; k < 3; k++) if (!commitValid_o) step();
    check_eq("pre_rst_cv", commitValid_o, 1'b1);
    commitReady_i = 1'b1;
    #2 reset_n_i = 1'b0;
    #1 check_quiet("mid_rst");
    @(posedge clk_i);
    #1 check_quiet("mid_rst_edge");
    reset_n_i = 1'b1;
    step();

    // Out-of-order completion must still retire 0,1,2 two cycles apart.
    commitReady_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alloc_i = 1'b1; allocDest_i = RW'(5 + k);
      step();
    end
    alloc_i = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      cdbValid_i = 1'b1; cdbTag_i = AW'(k); cdbData_i = 32'hA0 + 32'(k);
      step();
    end
    cdbValid_i = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 12; c++) begin
      if (updateHead_o && n_pulse < 3) begin
        p_tag[n_pulse]  = commitTag_o;
        p_dest[n_pulse] = commitDest_o;
        p_data[n_pulse] = commitData_o;
        p_cyc[n_pulse]  = c;
        n_pulse++;
      end
      step();
    end
    check_eq("ord_npulse", n_pulse, 3);
    for (int k = 0; k < 3; k++) begin
      if (k < n_pulse) begin
        check_eq("ord_tag", p_tag[k], AW'(k));
        check_eq("ord_dest", p_dest[k], RW'(5 + k));
        check_eq("ord_data", p_data[k], 32'hA0 + 32'(k));
        if (k > 0) check_eq("ord_gap", p_cyc[k] - p_cyc[k-1], 2);
      end
    end

    // Exception at the head flushes; entry 0 is valid beforehand and must be gone afterwards.
    for (int k = 0; k < 6; k++) begin
      alloc_i = 1'b1; allocDest_i = RW'(k);
      step();
    end
    alloc_i = 1'b0;
    cdbValid_i = 1'b1; cdbTag_i = 3'd3; cdbData_i = 32'hBAD; cdbExc_i = 1'b1;
    step();
    cdbValid_i = 1'b0; cdbExc_i = 1'b0;
    n_flush = 0;
    for (int c = 0; c < 5; c++) begin
      check_eq("fl_cv", commitValid_o, 1'b0);
      if (flush_o) begin
        n_flush++;
        check_eq("fl_state", state_o, 2'd2);
      end
      step();
    end
    check_eq("fl_count", n_flush, 1);
    cdbValid_i = 1'b1; cdbTag_i = 3'd0; cdbData_i = 32'h55;
    step();
    cdbValid_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_eq("stale_cv", commitValid_o, 1'b0);
      step();
    end

    // Random traffic against the ROB model.
    wait_cnt   = 0;
    prev_flush = 1'b0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      commitReady_i = ($urandom_range(3) != 0);
      #1;
      check_eq("r_upd", updateHead_o, commitValid_o & commitReady_i);
      if (commitValid_o) begin
        check_eq("r_tag", commitTag_o, m_head);
        check_eq("r_head_ok", {m_valid[m_head], m_done[m_head], m_exc[m_head]}, 3'b110);
        check_eq("r_dest", commitDest_o, m_dest[m_head]);
        check_eq("r_data", commitData_o, m_data[m_head]);
      end
      if (flush_o) begin
        check_eq("r_fl_head", {m_valid[m_head], m_done[m_head], m_exc[m_head]}, 3'b111);
        check_eq("r_fl_once", prev_flush, 1'b0);
        check_eq("r_fl_cv", commitValid_o, 1'b0);
      end
      if (m_valid[m_head] && m_done[m_head] && !commitValid_o && !flush_o) wait_cnt++;
      else wait_cnt = 0;
      check_eq("r_stall", wait_cnt > 2, 1'b0);
      prev_flush = flush_o;

      alloc_i     = !flush_o && (m_count < N) && ($urandom_range(1) == 1);
      allocDest_i = RW'($urandom);
      cand.delete();
      for (int k = 0; k < m_count; k++) begin
        idx = m_head + AW'(k);
        if (m_valid[idx] && !m_done[idx]) cand.push_back(idx);
      end
      cdbExc_i  = ($urandom_range(15) == 0);
      cdbData_i = $urandom;
      rtag      = AW'($urandom);
      if (cand.size() > 0 && $urandom_range(2) != 0) begin
        cdbValid_i = 1'b1;
        cdbTag_i   = cand[$urandom_range(cand.size() - 1)];
      end else if (!m_valid[rtag] && !(alloc_i && rtag == m_tail)) begin
        cdbValid_i = 1'b1;
        cdbTag_i   = rtag;
      end else begin
        cdbValid_i = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- In-order retire engine on the read (head) side of the ROB.
- Owns per-entry storage: valid/done/exception/dest/data.
- Entries are allocated at the tail and completed by CDB writeback; this block retires them in order from the head.
- Drives the head-advance pulse back to the ROB head/tail pointer manager and presents committed results to the architectural register file. An exception at the head triggers a full flush.

Parameters:
ROBsize, 8, number of ROB entries (power of two)
addrSize, $clog2(ROBsize), entry index width
regAddrSize, 5, architectural destination register index width
dataWidth, 32, result data width

Ports:
clk_i  in  1  clock, all state on rising edge
reset_n_i  in  1  asynchronous, active-low reset
alloc_i  in  1  allocate an entry this cycle
allocTail_i  in  addrSize  index being allocated (pointer manager tail)
allocDest_i  in  regAddrSize  destination register of the allocated instruction
cdbValid_i  in  1  CDB writeback valid
cdbTag_i  in  addrSize  ROB index completing
cdbData_i  in  dataWidth  result value
cdbExc_i  in  1  completing instruction raised an exception
head_i  in  addrSize  current head index from the pointer manager
commitReady_i  in  1  register file accepts a commit
commitValid_o  out  1  commit offer valid
commitDest_o  out  regAddrSize  committed destination register
commitData_o  out  dataWidth  committed value
commitTag_o  out  addrSize  ROB index being committed
updateHead_o  out  1  one-cycle head-advance pulse to the pointer manager
flush_o  out  1  one-cycle flush pulse
state_o  out  2  FSM state, for debug

Behaviour:
- Reset (async, reset_n_i=0):
  - All entry valid/done/exc bits cleared; state=IDLE.
  - commitValid_o=0, updateHead_o=0, flush_o=0; commitDest_o/commitData_o/commitTag_o=0.
- Alloc:
  - Edge with alloc_i=1: entry[allocTail_i] gets valid=1, done=0, exc=0, dest=allocDest_i.
- CDB writeback:
  - Edge with cdbValid_i=1 and entry[cdbTag_i].valid=1: done=1, data=cdbData_i, exc=cdbExc_i.
  - CDB to an invalid entry is ignored.
- Same-edge alloc and CDB to one index: alloc wins.
- FSM states: IDLE=0, COMMIT=1, FLUSH=2.
- IDLE:
  - If entry[head_i] is valid, done and exc=0: register dest/data/tag, set commitValid_o=1, go to COMMIT.
  - If valid, done and exc=1: go to FLUSH.
  - Otherwise stay in IDLE.
- COMMIT:
  - Outputs hold stable while commitReady_i=0.
  - updateHead_o = commitValid_o & commitReady_i (combinational).
  - On the handshake edge: entry[commitTag_o].valid=0, commitValid_o=0, go to IDLE.
- FLUSH:
  - flush_o=1 for exactly one cycle.
  - On that edge: clear all valid/done/exc bits; no commit and no updateHead_o; go to IDLE.
- Latency:
  - Head entry becomes done at edge N → commitValid_o high from N+1.
  - Peak throughput is 1 commit per 2 cycles: a one-cycle bubble in IDLE while head_i advances.
- CDB completing the head entry while in IDLE: the done bit is seen next cycle; no bypass by default.
- Alloc and retire of the same index on one edge: alloc wins. The entry stays valid with done=0 and must not be re-committed. This cannot occur when the pointer manager stall is honoured.
- Index arithmetic wraps modulo ROBsize.
- head_i is used only as an index; this block never computes pointers.
- Reset asserted mid-COMMIT or mid-FLUSH aborts immediately; no pulses are emitted.
- alloc_i during FLUSH is dropped; the upstream stall must hold alloc low.

Optional Feature:
Macro ROB_COMMIT_BYPASS_EN.
- Defined: in IDLE, if cdbValid_i=1, cdbTag_i==head_i, entry valid and cdbExc_i=0, then commitValid_o rises on the same edge that writes the entry, using cdbData_i. This saves one cycle.
- Undefined: no forwarding; latency as above.

Decomposition:
- Package rob_pkg:
  - robEntry_t struct {valid, done, exc, dest, data}
  - commitState_t enum {IDLE, COMMIT, FLUSH}
  - default widths
- Sub-module rob_entry_array: entry storage with alloc write port, CDB write port, global clear, and one async read port at head_i.

Test Plan:
- Reset low mid-run with commitValid_o=1 → all outputs 0 immediately, state_o=0, no updateHead_o.
- Alloc idx0 dest=3; CDB tag0 data=0xDEAD at edge N; commitReady_i=1 → commitValid_o=1, commitDest_o=3, commitData_o=0xDEAD at N+1; updateHead_o pulse at N+1.
- Alloc 0..2; CDB order 2,1,0 → commits in order 0,1,2, each 2 cycles apart.
- commitReady_i=0 for 4 cycles → outputs held stable, updateHead_o=0 throughout; single pulse when ready rises.
- Head entry completes with cdbExc_i=1 → flush_o one cycle, all entries invalid, no commitValid_o; a later CDB to a flushed tag is ignored.
- Bypass build: CDB to the head at edge N → commitValid_o at N; non-bypass build → N+1.
